mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one 64-bit memory request port between the instruction fetch bus (ibus) and the data bus (dbus).
// Sits between the CPU-side bus slaves and the memory/bridge side, and serialises one transaction at a time.
// Data has priority over fetch, with a starvation limit that forces an ibus grant.
// Returns rddata and drops stall to the owning requester on completion.
// PARAMETERS
// ADDR_WIDTH    32  byte address width; addresses are 8-byte aligned, and bits[2:0] are ignored and driven 0
// DATA_WIDTH    64  beat width; BE_WIDTH = DATA_WIDTH/8
// STARVE_LIMIT  4   max consecutive dbus grants while an ibus read waits; 1..15
// PORTS
// clk            in   1    clock, rising edge
// rst_n          in   1    reset, asynchronous assert, active-low
// ib_read        in   1    fetch read request; held stable while ib_stall=1
// ib_address     in   32   fetch address
// ib_stall       out  1    = ib_read & ~ib_done
// ib_rddata      out  64   fetch data; valid when ib_read=1 and ib_stall=0
// db_read        in   1    data read request
// db_write       in   1    data write request; db_read and db_write are never both 1
// db_address     in   32   data address
// db_byteenable  in   8    write byte lanes
// db_wrdata      in   64   write data
// db_stall       out  1    = (db_read|db_write) & ~db_done
// db_rddata      out  64   read data; valid when db_stall falls
// mem_req        out  1    memory request valid
// mem_we         out  1    1 = write
// mem_addr       out  32   aligned address
// mem_be         out  8    byte enables; 8'hFF on reads
// mem_wdata      out  64   write data
// mem_gnt        in   1    request accepted when mem_req & mem_gnt
// mem_rvalid     in   1    response (read data or write ack), one per accepted request
// mem_rdata      in   64   read data, qualified by mem_rvalid
// BEHAVIOUR
// Reset: state=IDLE; mem_req=0, mem_we=0, mem_addr/be/wdata=0; starve_cnt=0; owner=NONE.
//   ib_done=db_done=0; rddata outputs=0.
// FSM IDLE -> REQ -> RESP -> IDLE.
//  IDLE: choose owner.
//    dbus wins if requesting, unless ib_read=1 and starve_cnt==STARVE_LIMIT; otherwise ibus.
//    Latch we/addr/be/wdata into registers; go to REQ next cycle.
//    Result: 1-cycle arbitration bubble; mem_req is registered.
//  REQ: mem_req=1 with latched fields held stable until mem_gnt.
//    If mem_req & mem_gnt -> RESP; mem_req drops next cycle.
//  RESP: wait for mem_rvalid, then capture mem_rdata into owner's rddata register.
//    Assert owner's done for exactly 1 cycle (the following cycle); state -> IDLE.
//  mem_rvalid in the same cycle as mem_gnt is legal: REQ goes directly to the done/IDLE path.
//  Min latency request->stall low: 3 cycles (arb, req+gnt, rvalid), with done visible the cycle after rvalid.
// done pulse: CPU advances on stall=0.
//   Arbiter ignores that requester in the IDLE evaluation of the same cycle (new request is seen next cycle).
// starve_cnt: +1 per dbus grant while ib_read=1, saturating at STARVE_LIMIT; cleared on any ibus grant or when ib_read=0.
// Requester drops request before done (pipeline flush):
//   transaction still completes on memory side; response discarded; done not asserted.
//   Stall for that port follows its own formula (0 once request is dropped).
// A requester that is not the owner sees stall=1 whenever requesting.
// mem_rvalid while in IDLE/REQ-without-gnt: protocol error; ignored (assertion in bench).
// Reset mid-transaction: immediate return to IDLE, outstanding response lost; memory side is reset together with this block.
// STRUCTURE
// Shared package (common_defs): mem_owner_t enum {OWN_NONE, OWN_IB, OWN_DB}; arbiter state enum.
//   MEM_BE_ALL = 8'hFF.
// Sub-module arb_prio_tracker: holds starve_cnt and decides grant from (ib_req, db_req).
// Top holds FSM, latched request fields, and rddata/done registers.
// TESTING
// ib_read=1 @0x1000 only; mem_gnt=1, rvalid 2 cycles later, rdata=64'hDEAD_BEEF_0123_4567
//   -> ib_stall falls exactly once with that data; mem_be=FF, mem_we=0.
// db_write @0x2008, be=8'h0F, wdata=64'h1111 -> mem_we=1, addr=0x2008, be=0F; db_stall falls the cycle after ack.
// ib_read and db_read held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
// db_read is dropped while in RESP -> memory completes; db_rddata unchanged; no done pulse; next ib_read served normally.
// mem_gnt=0 for 5 cycles -> mem_req, addr, be, wdata held stable; single transaction issued after gnt.
// rst_n low during RESP with ib_read=1 -> all outputs at reset values; after release, the ib_read is re-arbitrated and completes.

Source files
------------

// File: rtl/common_defs.sv
// Shared types for the memory port arbiter: requester ownership, FSM states
// and the all-lanes byte enable used for reads.
package common_defs;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IB   = 2'd1,
        OWN_DB   = 2'd2
    } mem_owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic [7:0] MEM_BE_ALL = 8'hFF;

endpackage

// File: rtl/arb_prio_tracker.sv
// Grant decision for the shared memory port. Data normally wins; a counter of
// consecutive data grants taken while a fetch waits forces one fetch grant
// once it reaches STARVE_LIMIT.
module arb_prio_tracker #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ib_waiting,   // raw fetch request level, keeps the count alive
    input  logic ib_req,       // fetch request eligible for this evaluation
    input  logic db_req,       // data request eligible for this evaluation
    input  logic arb_en,       // a grant may be issued this cycle
    output logic grant_ib,
    output logic grant_db
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       starved;

    // Grant selection and saturating starvation count update.
    always_comb begin
        starved      = ib_waiting && (starve_cnt_q == LIMIT);
        grant_db     = arb_en && db_req && !(starved && ib_req);
        grant_ib     = arb_en && ib_req && !grant_db;
        starve_cnt_d = starve_cnt_q;
        if (!ib_waiting || grant_ib) begin
            starve_cnt_d = 4'd0;
        end else if (grant_db && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between the fetch bus (ib) and the data bus
// (db), one transaction at a time: IDLE (arbitrate/latch) -> REQ -> RESP.
//
// Handshakes: a memory request transfers on a cycle where mem_req & mem_gnt;
// the request fields stay stable from mem_req rising until that cycle. Exactly
// one mem_rvalid comes back per accepted request, no earlier than the grant
// cycle. CPU side: a requester holds its request until its stall drops; the
// cycle stall is low is the completion cycle.
module mem_port_arbiter
    import common_defs::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ib_read,
    input  logic [ADDR_WIDTH-1:0]   ib_address,
    output logic                    ib_stall,
    output logic [DATA_WIDTH-1:0]   ib_rddata,
    input  logic                    db_read,
    input  logic                    db_write,
    input  logic [ADDR_WIDTH-1:0]   db_address,
    input  logic [DATA_WIDTH/8-1:0] db_byteenable,
    input  logic [DATA_WIDTH-1:0]   db_wrdata,
    output logic                    db_stall,
    output logic [DATA_WIDTH-1:0]   db_rddata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output arb_state_t              dbg_state
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_t                state_q, state_d;
    mem_owner_t                owner_q, owner_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [BE_WIDTH-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      ib_done_q, ib_done_d;
    logic                      db_done_q, db_done_d;
    logic [DATA_WIDTH-1:0]     ib_rdata_q, ib_rdata_d;
    logic [DATA_WIDTH-1:0]     db_rdata_q, db_rdata_d;
    logic                      db_active;
    logic                      arb_en;
    logic                      grant_ib, grant_db;
    logic                      complete;

    assign db_active = db_read | db_write;

    // A completing requester cannot yet be told apart from its next request,
    // so the done cycle issues no grant at all; this also keeps data priority
    // intact when both buses stream back-to-back.
    assign arb_en = (state_q == ST_IDLE) && !ib_done_q && !db_done_q;

    arb_prio_tracker #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .ib_waiting (ib_read),
        .ib_req     (ib_read & ~ib_done_q),
        .db_req     (db_active & ~db_done_q),
        .arb_en     (arb_en),
        .grant_ib   (grant_ib),
        .grant_db   (grant_db)
    );

    // Next-state, request latching and completion handling.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ib_done_d  = 1'b0;
        db_done_d  = 1'b0;
        ib_rdata_d = ib_rdata_q;
        db_rdata_d = db_rdata_q;
        complete   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ib) begin
                    owner_d = OWN_IB;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {ib_address[ADDR_WIDTH-1:3], 3'b000};
                    be_d    = {BE_WIDTH{1'b1}};
                    wdata_d = '0;
                    state_d = ST_REQ;
                end else if (grant_db) begin
                    owner_d = OWN_DB;
                    req_d   = 1'b1;
                    we_d    = db_write;
                    addr_d  = {db_address[ADDR_WIDTH-1:3], 3'b000};
                    be_d    = db_write ? db_byteenable : {BE_WIDTH{1'b1}};
                    wdata_d = db_write ? db_wrdata : '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    req_d = 1'b0;
                    if (mem_rvalid) begin
                        complete = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A requester that dropped its request (flush) gets neither data nor done.
        if (complete) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            if ((owner_q == OWN_IB) && ib_read) begin
                ib_done_d  = 1'b1;
                ib_rdata_d = mem_rdata;
            end
            if ((owner_q == OWN_DB) && db_active) begin
                db_done_d = 1'b1;
                // Write acks carry no data; keep the last read result.
                if (!we_q) begin
                    db_rdata_d = mem_rdata;
                end
            end
        end
    end

    // State, request fields and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            ib_done_q  <= 1'b0;
            db_done_q  <= 1'b0;
            ib_rdata_q <= '0;
            db_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ib_done_q  <= ib_done_d;
            db_done_q  <= db_done_d;
            ib_rdata_q <= ib_rdata_d;
            db_rdata_q <= db_rdata_d;
        end
    end

    assign ib_stall  = ib_read & ~ib_done_q;
    assign db_stall  = db_active & ~db_done_q;
    assign ib_rddata = ib_rdata_q;
    assign db_rddata = db_rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized concurrent
// traffic, checked against a memory/reference model kept in the bench.
module tb_mem_port_arbiter;
    import common_defs::*;

    localparam int LIMIT = 4;

    logic        clk, rst_n;
    logic        ib_read, db_read, db_write;
    logic [31:0] ib_address, db_address;
    logic [7:0]  db_byteenable;
    logic [63:0] db_wrdata;
    logic        ib_stall, db_stall;
    logic [63:0] ib_rddata, db_rddata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;
    arb_state_t  dbg_state;

    int total = 0;
    int bad   = 0;

    // memory-side configuration and transaction log
    int          gnt_wait_cfg = 0;
    int          rv_delay_cfg = 1;
    bit          force_en     = 0;
    logic [63:0] force_data   = '0;
    logic [63:0] phys_mem [logic [31:0]];
    logic [63:0] ref_mem  [logic [31:0]];
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [7:0]  log_be   [$];
    logic [63:0] log_wdata[$];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ib_read(ib_read), .ib_address(ib_address), .ib_stall(ib_stall), .ib_rddata(ib_rddata),
        .db_read(db_read), .db_write(db_write), .db_address(db_address),
        .db_byteenable(db_byteenable), .db_wrdata(db_wrdata), .db_stall(db_stall),
        .db_rddata(db_rddata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {a, ~a} ^ 64'h5A5A_0000_C3C3_0000;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                          input logic [63:0] wd);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // memory responder: grant after gnt_wait_cfg cycles, respond rv_delay_cfg cycles after grant
    initial begin : responder
        bit          pending;
        int          rsp_cnt, wait_cnt;
        logic [63:0] pend_data;
        pending = 0; rsp_cnt = 0; wait_cnt = 0; pend_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0; pending = 0; wait_cnt = 0;
                continue;
            end
            #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (pending) begin
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = pend_data; pending = 0;
                end else begin
                    rsp_cnt--;
                end
            end else if (mem_req) begin
                if (wait_cnt < gnt_wait_cfg) begin
                    wait_cnt++;
                end else begin
                    mem_gnt = 1'b1; wait_cnt = 0;
                    log_addr.push_back(mem_addr); log_we.push_back(mem_we);
                    log_be.push_back(mem_be); log_wdata.push_back(mem_wdata);
                    if (mem_we) begin
                        phys_mem[mem_addr] = merge(phys_mem.exists(mem_addr) ? phys_mem[mem_addr]
                                                   : dflt(mem_addr), mem_be, mem_wdata);
                        pend_data = '0;
                    end else begin
                        pend_data = force_en ? force_data :
                                    (phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr));
                    end
                    if (rv_delay_cfg == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = pend_data;
                    end else begin
                        pending = 1; rsp_cnt = rv_delay_cfg - 1;
                    end
                end
            end
        end
    end

    task automatic ib_op(input logic [31:0] a, output logic [63:0] d, output int lat, output bit ok);
        @(posedge clk); #1;
        ib_read = 1'b1; ib_address = a;
        lat = 0; ok = 0; d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ib_stall) begin ok = 1; d = ib_rddata; break; end
            lat++;
        end
        @(posedge clk); #1;
        ib_read = 1'b0;
    endtask

    task automatic db_op(input logic we, input logic [31:0] a, input logic [7:0] be,
                         input logic [63:0] wd, output logic [63:0] d, output int lat, output bit ok);
        @(posedge clk); #1;
        db_read = !we; db_write = we; db_address = a; db_byteenable = be; db_wrdata = wd;
        lat = 0; ok = 0; d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!db_stall) begin ok = 1; d = db_rddata; break; end
            lat++;
        end
        @(posedge clk); #1;
        db_read = 1'b0; db_write = 1'b0;
    endtask

    initial begin : main
        logic [63:0] d, prev;
        int          lat, n0, hi, unstable;
        bit          ok, seen;
        byte         exp_g, obs_g;
        int          sc;

        rst_n = 1'b0; ib_read = 0; db_read = 0; db_write = 0;
        ib_address = '0; db_address = '0; db_byteenable = '0; db_wrdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_ib_rddata", ib_rddata, 0);
        check("rst_db_rddata", db_rddata, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // single fetch, response two cycles after grant
        force_en = 1; force_data = 64'hDEAD_BEEF_0123_4567;
        gnt_wait_cfg = 0; rv_delay_cfg = 2; log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
        ib_op(32'h1000, d, lat, ok);
        force_en = 0;
        check("ib1_done", ok, 1);
        check("ib1_data", d, 64'hDEAD_BEEF_0123_4567);
        check("ib1_latency", lat, 2 + 2);
        repeat (4) @(negedge clk);
        check("ib1_txn_count", log_addr.size(), 1);
        check("ib1_addr", log_addr[0], 32'h1000);
        check("ib1_we", log_we[0], 0);
        check("ib1_be", log_be[0], MEM_BE_ALL);

        // data write with partial lanes, ack one cycle after grant
        rv_delay_cfg = 1;
        db_op(1'b1, 32'h2008, 8'h0F, 64'h1111, d, lat, ok);
        ref_mem[32'h2008] = merge(ref_rd(32'h2008), 8'h0F, 64'h1111);
        check("dbw_done", ok, 1);
        check("dbw_latency", lat, 2 + 1);
        check("dbw_we", log_we[1], 1);
        check("dbw_addr", log_addr[1], 32'h2008);
        check("dbw_be", log_be[1], 8'h0F);
        check("dbw_wdata", log_wdata[1], 64'h1111);
        db_op(1'b0, 32'h200F, 8'h00, 64'h0, d, lat, ok);
        check("dbr_done", ok, 1);
        check("dbr_data", d, ref_rd(32'h2008));
        check("dbr_addr_aligned", log_addr[2], 32'h2008);
        check("dbr_be", log_be[2], MEM_BE_ALL);

        // response in the grant cycle
        rv_delay_cfg = 0;
        ib_op(32'h1010, d, lat, ok);
        check("ib_rv0_data", d, dflt(32'h1010));
        check("ib_rv0_latency", lat, 2);

        // both buses held: data first, fetch forced every LIMIT data grants
        rv_delay_cfg = 1; n0 = log_addr.size();
        @(posedge clk); #1;
        ib_read = 1; ib_address = 32'h1100; db_read = 1; db_address = 32'h2100;
        for (int i = 0; i < 400 && log_addr.size() < n0 + 10; i++) @(negedge clk);
        @(posedge clk); #1;
        ib_read = 0; db_read = 0;
        repeat (10) @(negedge clk);
        check("grant_count", log_addr.size() >= n0 + 10, 1);
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            if (sc == LIMIT) begin exp_g = "I"; sc = 0; end
            else begin exp_g = "D"; sc++; end
            obs_g = (log_addr.size() > n0 + i) ? (log_addr[n0+i] == 32'h2100 ? "D" : "I") : "-";
            check($sformatf("grant_order_%0d", i), obs_g, exp_g);
        end

        // data read flushed while awaiting the response
        rv_delay_cfg = 4; prev = db_rddata; n0 = log_addr.size();
        @(posedge clk); #1;
        db_read = 1; db_address = 32'h2200;
        for (int i = 0; i < 50 && log_addr.size() == n0; i++) @(negedge clk);
        @(posedge clk); #1;
        db_read = 0;
        @(negedge clk);
        check("flush_db_stall", db_stall, 0);
        repeat (8) @(negedge clk);
        check("flush_mem_completed", log_addr.size(), n0 + 1);
        check("flush_rddata_kept", db_rddata, prev);
        ib_op(32'h1300, d, lat, ok);
        check("flush_next_ib_data", d, dflt(32'h1300));
        check("flush_next_ib_latency", lat, 2 + 4);

        // grant withheld: request fields must hold steady
        gnt_wait_cfg = 5; rv_delay_cfg = 1; n0 = log_addr.size(); hi = 0; unstable = 0;
        fork
            db_op(1'b1, 32'h2310, 8'hA5, 64'h0123_4567_89AB_CDEF, d, lat, ok);
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (mem_req) begin
                        hi++;
                        if (mem_we !== 1'b1 || mem_addr !== 32'h2310 || mem_be !== 8'hA5 ||
                            mem_wdata !== 64'h0123_4567_89AB_CDEF) unstable++;
                    end
                end
            end
        join
        ref_mem[32'h2310] = merge(ref_rd(32'h2310), 8'hA5, 64'h0123_4567_89AB_CDEF);
        check("hold_req_cycles", hi, 5 + 1);
        check("hold_unstable", unstable, 0);
        check("hold_single_txn", log_addr.size(), n0 + 1);
        check("hold_latency", lat, 2 + 5 + 1);

        // reset during the response phase of a fetch
        gnt_wait_cfg = 0; rv_delay_cfg = 6; n0 = log_addr.size();
        @(posedge clk); #1;
        ib_read = 1; ib_address = 32'h1400;
        for (int i = 0; i < 50 && log_addr.size() == n0; i++) @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_be", mem_be, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_ib_rddata", ib_rddata, 0);
        check("midrst_db_rddata", db_rddata, 0);
        check("midrst_ib_stall", ib_stall, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0; d = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ib_stall) begin seen = 1; d = ib_rddata; break; end
        end
        @(posedge clk); #1;
        ib_read = 0;
        check("midrst_rearb_done", seen, 1);
        check("midrst_rearb_data", d, dflt(32'h1400));
        check("midrst_txn_count", log_addr.size(), n0 + 2);
        ref_mem.delete();
        phys_mem.delete();

        // randomized concurrent traffic
        for (int r = 0; r < 4; r++) begin
            gnt_wait_cfg = $urandom_range(0, 2);
            rv_delay_cfg = $urandom_range(0, 3);
            fork
                begin
                    logic [31:0] ia; logic [63:0] id; int il; bit iok;
                    for (int k = 0; k < 10; k++) begin
                        ia = 32'h1000 + 32'($urandom_range(0, 511)) * 8;
                        ib_op(ia, id, il, iok);
                        check("rand_ib_done", iok, 1);
                        check("rand_ib_data", id, dflt(ia));
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                    end
                end
                begin
                    logic [31:0] da; logic [63:0] dd, dw; logic [7:0] dbe; logic dwe; int dl; bit dok;
                    for (int k = 0; k < 10; k++) begin
                        dwe = 1'($urandom_range(0, 1));
                        da  = 32'h2000 + 32'($urandom_range(0, 31)) * 8;
                        dbe = 8'($urandom);
                        dw  = {$urandom, $urandom};
                        db_op(dwe, da, dbe, dw, dd, dl, dok);
                        check("rand_db_done", dok, 1);
                        if (dwe) ref_mem[da] = merge(ref_rd(da), dbe, dw);
                        else check("rand_db_data", dd, ref_rd(da));
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                    end
                end
            join
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
